// File: rtl/memory_request_responder.sv
// Memory-side responder: accepts one read/write at a time, holds mem_busy for
// LATENCY cycles (request cycle included), then performs the access on a byte-lane RAM.
module memory_request_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 4
) (
  input  logic        clk,
  input  logic        nRst,
  input  logic        read_to_mem,
  input  logic        write_to_mem,
  input  logic [3:0]  sel_to_mem,
  input  logic [31:0] adr_to_mem,
  input  logic [31:0] data_to_mem,
  output logic        mem_busy,
  output logic [31:0] data_from_mem
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t        state, state_next;
  logic          req;
  logic          fire;
  logic [CW-1:0] counter;

  logic          op_q;
  logic [31:2]   adr_q;
  logic [3:0]    sel_q;
  logic [31:0]   data_q;

  logic          acc_write;
  logic [31:2]   acc_adr;
  logic [3:0]    acc_sel;
  logic [31:0]   acc_data;
  logic          in_range;
  logic [AW-1:0] idx;
  logic [31:0]   mask;
  logic          unused_adr_lsbs;

  logic [31:0]   ram [DEPTH_WORDS];

  assign req             = read_to_mem | write_to_mem;
  assign unused_adr_lsbs = ^adr_to_mem[1:0];

  // The request cycle is the first busy cycle, so BUSY lasts LATENCY-1 cycles;
  // with LATENCY==1 the access happens on the accepting edge and BUSY is skipped.
  always_comb begin
    fire = 1'b0;
    case (state)
      IDLE:    fire = req && (LATENCY == 1);
      BUSY:    fire = (counter == CW'(1));
      default: fire = 1'b0;
    endcase
  end

  always_comb begin
    if (state == IDLE) begin
      acc_write = write_to_mem;
      acc_adr   = adr_to_mem[31:2];
      acc_sel   = sel_to_mem;
      acc_data  = data_to_mem;
    end else begin
      acc_write = op_q;
      acc_adr   = adr_q;
      acc_sel   = sel_q;
      acc_data  = data_q;
    end
    idx      = acc_adr[AW+1:2];
    in_range = ~|acc_adr[31:AW+2];
    for (int unsigned i = 0; i < 4; i++) mask[8*i +: 8] = {8{acc_sel[i]}};
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req) state_next = (LATENCY == 1) ? DONE : BUSY;
      BUSY:    if (counter == CW'(1)) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    case (state)
      IDLE:    mem_busy = req;
      BUSY:    mem_busy = 1'b1;
      default: mem_busy = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      counter       <= '0;
      op_q          <= 1'b0;
      adr_q         <= '0;
      sel_q         <= '0;
      data_q        <= '0;
      data_from_mem <= '0;
      for (int unsigned w = 0; w < DEPTH_WORDS; w++) ram[w] <= '0;
    end else begin
      if (state == IDLE && req) begin
        op_q    <= write_to_mem;
        adr_q   <= adr_to_mem[31:2];
        sel_q   <= sel_to_mem;
        data_q  <= data_to_mem;
        counter <= CW'(LATENCY - 1);
      end else if (state == BUSY && counter != CW'(1)) begin
        counter <= counter - 1'b1;
      end
      if (fire && !acc_write)
        data_from_mem <= in_range ? (ram[idx] & mask) : '0;
      if (fire && acc_write && in_range) begin
        for (int unsigned i = 0; i < 4; i++)
          if (acc_sel[i]) ram[idx][8*i +: 8] <= acc_data[8*i +: 8];
      end
    end
  end
endmodule

// File: tb/tb_memory_request_responder.sv
// Self-checking bench: directed table, reset/LATENCY=1 sequences, back-to-back
// reads and randomized traffic against a behavioural memory model.
module tb_memory_request_responder;
  logic        clk = 1'b0;
  logic        nRst;
  logic        rd, wr;
  logic [3:0]  sel;
  logic [31:0] adr, din, dout;
  logic        busy;
  logic        l1_rd, l1_wr;
  logic [3:0]  l1_sel;
  logic [31:0] l1_adr, l1_din, l1_dout;
  logic        l1_busy;

  int n_vec = 0;
  int n_bad = 0;

  logic [31:0] ref_mem [256];
  logic [31:0] ref_dout;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl [15];

  memory_request_responder #(.DEPTH_WORDS(256), .LATENCY(4)) dut (
    .clk(clk), .nRst(nRst), .read_to_mem(rd), .write_to_mem(wr),
    .sel_to_mem(sel), .adr_to_mem(adr), .data_to_mem(din),
    .mem_busy(busy), .data_from_mem(dout)
  );

  memory_request_responder #(.DEPTH_WORDS(256), .LATENCY(1)) dut1 (
    .clk(clk), .nRst(nRst), .read_to_mem(l1_rd), .write_to_mem(l1_wr),
    .sel_to_mem(l1_sel), .adr_to_mem(l1_adr), .data_to_mem(l1_din),
    .mem_busy(l1_busy), .data_from_mem(l1_dout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 256; i++) ref_mem[i] = 32'h0;
    ref_dout = 32'h0;
  endfunction

  // Memory of 256 words; anything at byte address 1024 or above is outside it.
  function automatic void model(input logic r, input logic w, input logic [3:0] s,
                                input logic [31:0] a, input logic [31:0] d);
    int unsigned word = a / 4;
    bit outside = (a >= 32'd1024);
    if (w) begin
      if (!outside)
        for (int i = 0; i < 4; i++)
          if (s[i]) ref_mem[word][8*i +: 8] = d[8*i +: 8];
    end else if (r) begin
      ref_dout = 32'h0;
      if (!outside)
        for (int i = 0; i < 4; i++)
          if (s[i]) ref_dout[8*i +: 8] = ref_mem[word][8*i +: 8];
    end
  endfunction

  task automatic txn(input bit which, input logic r, input logic w, input logic [3:0] s,
                     input logic [31:0] a, input logic [31:0] d, input bit hold,
                     output int hi, output logic [31:0] dq);
    hi = 0;
    if (which) begin l1_rd = r; l1_wr = w; l1_sel = s; l1_adr = a; l1_din = d; end
    else       begin rd = r; wr = w; sel = s; adr = a; din = d; end
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (!(which ? l1_busy : busy)) break;
      hi++;
      @(posedge clk); #1;
    end
    dq = which ? l1_dout : dout;
    if (!hold) begin
      if (which) begin l1_rd = 1'b0; l1_wr = 1'b0; end
      else       begin rd = 1'b0; wr = 1'b0; end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int hi;
    logic [31:0] dq;
    logic r, w;
    logic [3:0] s;
    logic [31:0] a, d;

    tbl[0]  = '{1'b0, 1'b1, 4'b1111, 32'h10,  32'hDEADBEEF, 32'h00000000};
    tbl[1]  = '{1'b1, 1'b0, 4'b1111, 32'h10,  32'h0,        32'hDEADBEEF};
    tbl[2]  = '{1'b0, 1'b1, 4'b1111, 32'h20,  32'h11223344, 32'hDEADBEEF};
    tbl[3]  = '{1'b0, 1'b1, 4'b0101, 32'h20,  32'hAABBCCDD, 32'hDEADBEEF};
    tbl[4]  = '{1'b1, 1'b0, 4'b1111, 32'h20,  32'h0,        32'h11BB33DD};
    tbl[5]  = '{1'b1, 1'b0, 4'b0011, 32'h20,  32'h0,        32'h000033DD};
    tbl[6]  = '{1'b0, 1'b1, 4'b1111, 32'h400, 32'hFFFFFFFF, 32'h000033DD};
    tbl[7]  = '{1'b1, 1'b0, 4'b1111, 32'h400, 32'h0,        32'h00000000};
    tbl[8]  = '{1'b1, 1'b0, 4'b1111, 32'h0,   32'h0,        32'h00000000};
    tbl[9]  = '{1'b0, 1'b1, 4'b1111, 32'h7,   32'h01020304, 32'h00000000};
    tbl[10] = '{1'b1, 1'b0, 4'b1111, 32'h4,   32'h0,        32'h01020304};
    tbl[11] = '{1'b1, 1'b1, 4'b1111, 32'h8,   32'h5A5A5A5A, 32'h01020304};
    tbl[12] = '{1'b1, 1'b0, 4'b1111, 32'h8,   32'h0,        32'h5A5A5A5A};
    tbl[13] = '{1'b0, 1'b1, 4'b0000, 32'h8,   32'h0,        32'h5A5A5A5A};
    tbl[14] = '{1'b1, 1'b0, 4'b1111, 32'hB,   32'h0,        32'h5A5A5A5A};

    nRst = 1'b0;
    rd = 1'b0; wr = 1'b0; sel = '0; adr = '0; din = '0;
    l1_rd = 1'b0; l1_wr = 1'b0; l1_sel = '0; l1_adr = '0; l1_din = '0;
    model_reset();
    #12;
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_dout", dout, 32'h0);
    check("reset_busy_l1", 32'(l1_busy), 32'h0);
    @(negedge clk); nRst = 1'b1;
    @(posedge clk); #1;

    // LATENCY=1 instance: simultaneous read+write acts as a write
    txn(1'b1, 1'b0, 1'b1, 4'hF, 32'h8, 32'h0000ABCD, 1'b0, hi, dq);
    check("l1_wr_busy", 32'(hi), 32'd1);
    txn(1'b1, 1'b1, 1'b0, 4'hF, 32'h8, 32'h0, 1'b0, hi, dq);
    check("l1_rd_busy", 32'(hi), 32'd1);
    check("l1_rd_dout", dq, 32'h0000ABCD);
    txn(1'b1, 1'b1, 1'b1, 4'hF, 32'h8, 32'h5A5A5A5A, 1'b0, hi, dq);
    check("l1_rw_busy", 32'(hi), 32'd1);
    check("l1_rw_dout_kept", dq, 32'h0000ABCD);
    txn(1'b1, 1'b1, 1'b0, 4'hF, 32'h8, 32'h0, 1'b0, hi, dq);
    check("l1_rd2_dout", dq, 32'h5A5A5A5A);

    // Reset in the middle of a write to word 3
    txn(1'b0, 1'b0, 1'b1, 4'hF, 32'hC, 32'hCAFEF00D, 1'b0, hi, dq);
    txn(1'b0, 1'b1, 1'b0, 4'hF, 32'hC, 32'h0, 1'b0, hi, dq);
    check("pre_reset_dout", dq, 32'hCAFEF00D);
    wr = 1'b1; sel = 4'hF; adr = 32'hC; din = 32'h12345678;
    @(posedge clk); #1;
    @(posedge clk); #3;
    nRst = 1'b0; rd = 1'b0; wr = 1'b0;
    #1;
    check("midreset_busy", 32'(busy), 32'h0);
    check("midreset_dout", dout, 32'h0);
    model_reset();
    @(negedge clk); nRst = 1'b1;
    @(posedge clk); #1;
    txn(1'b0, 1'b1, 1'b0, 4'hF, 32'hC, 32'h0, 1'b0, hi, dq);
    check("post_reset_word3", dq, 32'h0);

    for (int i = 0; i < 15; i++) begin
      txn(1'b0, tbl[i].rd, tbl[i].wr, tbl[i].sel, tbl[i].adr, tbl[i].data, 1'b0, hi, dq);
      model(tbl[i].rd, tbl[i].wr, tbl[i].sel, tbl[i].adr, tbl[i].data);
      check($sformatf("tbl%0d_busy", i), 32'(hi), 32'd4);
      check($sformatf("tbl%0d_dout", i), dq, tbl[i].exp);
    end

    // Back-to-back reads with read_to_mem held high throughout
    txn(1'b0, 1'b1, 1'b0, 4'hF, 32'h10, 32'h0, 1'b1, hi, dq);
    check("b2b0_busy", 32'(hi), 32'd4);
    check("b2b0_dout", dq, 32'hDEADBEEF);
    txn(1'b0, 1'b1, 1'b0, 4'hF, 32'h20, 32'h0, 1'b1, hi, dq);
    check("b2b1_busy", 32'(hi), 32'd4);
    check("b2b1_dout", dq, 32'h11BB33DD);
    txn(1'b0, 1'b1, 1'b0, 4'hF, 32'h4, 32'h0, 1'b0, hi, dq);
    check("b2b2_busy", 32'(hi), 32'd4);
    check("b2b2_dout", dq, 32'h01020304);
    ref_dout = 32'h01020304;

    for (int i = 0; i < 80; i++) begin
      r = 1'($urandom_range(0, 1));
      w = ($urandom_range(0, 3) == 0) ? 1'b1 : ~r;
      s = 4'($urandom);
      d = $urandom;
      a = 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) a = a | (32'h1 << $urandom_range(10, 31));
      txn(1'b0, r, w, s, a, d, 1'b0, hi, dq);
      model(r, w, s, a, d);
      check($sformatf("rnd%0d_busy", i), 32'(hi), 32'd4);
      check($sformatf("rnd%0d_dout", i), dq, ref_dout);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
